// File: rtl/altera_tse_reset_seq_chain.sv
// Multi-stage reset sequencer: drives one reset output per stage in strict order,
// waits for each stage's done to be stable, and retries the whole chain on timeout.
module altera_tse_reset_seq_chain #(
    parameter int unsigned                  NUM_STAGES         = 3,
    parameter logic [16*NUM_STAGES-1:0]     HOLD_CYCLES        = {16'd1, 16'd1, 16'd1},
    parameter logic [NUM_STAGES-1:0]        HOLD_TIL_RDONE     = '0,
    parameter int unsigned                  SDONE_DELAY_CYCLES = 0,
    parameter int unsigned                  TIMEOUT_CYCLES     = 0,
    parameter int unsigned                  MAX_RETRIES        = 2,
    localparam int unsigned                 SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clock,
    input  logic                  aclr,
    input  logic                  start,
    input  logic [NUM_STAGES-1:0] rdone,
    output logic [NUM_STAGES-1:0] reset,
    output logic                  sdone,
    output logic                  busy,
    output logic                  error,
    output logic [SW-1:0]         stage,
    output logic [3:0]            retry_count
);

    localparam int unsigned CW         = 16;
    localparam logic [CW-1:0] STAB_LAST = CW'(SDONE_DELAY_CYCLES);
    localparam bit            TMO_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] TMO_LAST  = TMO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [SW-1:0] LAST_STG  = SW'(NUM_STAGES - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_WAIT,
        ST_DONE,
        ST_FAIL
    } state_t;

    state_t                  state, state_nxt;
    logic [NUM_STAGES-1:0]   reset_nxt;
    logic                    sdone_nxt, error_nxt, busy_nxt;
    logic [SW-1:0]           stage_nxt;
    logic [3:0]              retry_nxt;
    logic [CW-1:0]           hold, hold_nxt;
    logic [CW-1:0]           stab, stab_nxt;
    logic [CW-1:0]           tmo, tmo_nxt;
    logic                    zstart;
    logic                    spulse;
    logic                    restart;

    // Hold counter preload: HOLD_CYCLES of 0 behaves as 1.
    function automatic logic [CW-1:0] hold_load(input logic [SW-1:0] idx);
        logic [CW-1:0] h;
        h = HOLD_CYCLES[CW*int'(idx) +: CW];
        return (h == '0) ? '0 : h - CW'(1);
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    assign spulse = start & ~zstart;

    // Next-state and output decode; start edge and restart override the state action.
    always_comb begin
        state_nxt = state;
        reset_nxt = reset;
        sdone_nxt = sdone;
        error_nxt = error;
        stage_nxt = stage;
        retry_nxt = retry_count;
        hold_nxt  = hold;
        stab_nxt  = stab;
        tmo_nxt   = tmo;
        restart   = 1'b0;

        if (spulse) begin
            restart   = 1'b1;
            retry_nxt = '0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (HOLD_TIL_RDONE[stage] ? rdone[stage] : (hold == '0)) begin
                        reset_nxt = '0;
                        state_nxt = ST_WAIT;
                        hold_nxt  = '0;
                        stab_nxt  = '0;
                        tmo_nxt   = '0;
                    end else if (!HOLD_TIL_RDONE[stage]) begin
                        hold_nxt = hold - CW'(1);
                    end
                end
                ST_WAIT: begin
                    tmo_nxt = sat_inc(tmo);
                    if (rdone[stage] && (stab == STAB_LAST)) begin
                        stab_nxt = '0;
                        tmo_nxt  = '0;
                        if (stage == LAST_STG) begin
                            state_nxt = ST_DONE;
                            sdone_nxt = 1'b1;
                        end else begin
                            stage_nxt            = stage + SW'(1);
                            state_nxt            = ST_ASSERT;
                            reset_nxt            = '0;
                            reset_nxt[stage_nxt] = 1'b1;
                            hold_nxt             = hold_load(stage_nxt);
                        end
                    end else begin
                        stab_nxt = rdone[stage] ? sat_inc(stab) : '0;
                        if (TMO_EN && (tmo == TMO_LAST)) begin
                            if (retry_count < RETRY_MAX) begin
                                retry_nxt = retry_count + 4'd1;
                                restart   = 1'b1;
                            end else begin
                                state_nxt = ST_FAIL;
                                error_nxt = 1'b1;
                                reset_nxt = '0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end

        if (restart) begin
            stage_nxt    = '0;
            sdone_nxt    = 1'b0;
            error_nxt    = 1'b0;
            state_nxt    = ST_ASSERT;
            reset_nxt    = '0;
            reset_nxt[0] = 1'b1;
            hold_nxt     = hold_load('0);
            stab_nxt     = '0;
            tmo_nxt      = '0;
        end

        busy_nxt = (state_nxt == ST_ASSERT) || (state_nxt == ST_WAIT);
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state       <= ST_IDLE;
            reset       <= '0;
            sdone       <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b0;
            stage       <= '0;
            retry_count <= '0;
            hold        <= '0;
            stab        <= '0;
            tmo         <= '0;
            zstart      <= 1'b0;
        end else begin
            state       <= state_nxt;
            reset       <= reset_nxt;
            sdone       <= sdone_nxt;
            busy        <= busy_nxt;
            error       <= error_nxt;
            stage       <= stage_nxt;
            retry_count <= retry_nxt;
            hold        <= hold_nxt;
            stab        <= stab_nxt;
            tmo         <= tmo_nxt;
            zstart      <= start;
        end
    end

endmodule

// File: tb/tb_altera_tse_reset_seq_chain.sv
// Directed bench: dut_a covers timed stages, timeout/retry, aclr and restarts;
// dut_b covers stability delay and a hold-until-done stage.
module tb_altera_tse_reset_seq_chain;

    logic       clk;
    logic       a_aclr, a_start;
    logic [2:0] a_rdone, a_reset;
    logic       a_sdone, a_busy, a_error;
    logic [1:0] a_stage;
    logic [3:0] a_retry;

    logic       b_aclr, b_start;
    logic [2:0] b_rdone, b_reset;
    logic       b_sdone, b_busy, b_error;
    logic [1:0] b_stage;
    logic [3:0] b_retry;

    int nvec  = 0;
    int nfail = 0;

    altera_tse_reset_seq_chain #(
        .NUM_STAGES(3), .HOLD_CYCLES({16'd1, 16'd2, 16'd4}), .HOLD_TIL_RDONE(3'b000),
        .SDONE_DELAY_CYCLES(0), .TIMEOUT_CYCLES(10), .MAX_RETRIES(2)
    ) dut_a (
        .clock(clk), .aclr(a_aclr), .start(a_start), .rdone(a_rdone),
        .reset(a_reset), .sdone(a_sdone), .busy(a_busy), .error(a_error),
        .stage(a_stage), .retry_count(a_retry)
    );

    altera_tse_reset_seq_chain #(
        .NUM_STAGES(3), .HOLD_CYCLES({16'd1, 16'd1, 16'd1}), .HOLD_TIL_RDONE(3'b010),
        .SDONE_DELAY_CYCLES(3), .TIMEOUT_CYCLES(0), .MAX_RETRIES(2)
    ) dut_b (
        .clock(clk), .aclr(b_aclr), .start(b_start), .rdone(b_rdone),
        .reset(b_reset), .sdone(b_sdone), .busy(b_busy), .error(b_error),
        .stage(b_stage), .retry_count(b_retry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output bundle: {reset, sdone, busy, error, stage, retry_count}.
    function automatic logic [11:0] pk(input logic [2:0] r, input logic s, input logic b,
                                       input logic e, input logic [1:0] st, input logic [3:0] rc);
        return {r, s, b, e, st, rc};
    endfunction

    task automatic check_a(input string name, input logic [11:0] exp);
        logic [11:0] got;
        got = pk(a_reset, a_sdone, a_busy, a_error, a_stage, a_retry);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got {rst,sd,bsy,err,stg,rty}=%b want %b", name, got, exp);
        end
    endtask

    task automatic check_b(input string name, input logic [11:0] exp);
        logic [11:0] got;
        got = pk(b_reset, b_sdone, b_busy, b_error, b_stage, b_retry);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got {rst,sd,bsy,err,stg,rty}=%b want %b", name, got, exp);
        end
    endtask

    task automatic step_a(input logic s, input logic [2:0] r);
        @(negedge clk);
        a_start = s;
        a_rdone = r;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic s, input logic [2:0] r);
        @(negedge clk);
        b_start = s;
        b_rdone = r;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        start;
        logic [2:0]  rdone;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[13];
    logic pat[7];

    initial begin
        a_aclr = 1'b1; a_start = 1'b0; a_rdone = 3'b000;
        b_aclr = 1'b1; b_start = 1'b0; b_rdone = 3'b000;

        // HOLD={4,2,1}, rdone tied high, then DONE, rdone drop, and start re-edge in DONE.
        tbl[0]  = '{1'b1, 3'b111, pk(3'b001, 0, 1, 0, 2'd0, 4'd0)};
        tbl[1]  = '{1'b0, 3'b111, pk(3'b001, 0, 1, 0, 2'd0, 4'd0)};
        tbl[2]  = '{1'b0, 3'b111, pk(3'b001, 0, 1, 0, 2'd0, 4'd0)};
        tbl[3]  = '{1'b0, 3'b111, pk(3'b001, 0, 1, 0, 2'd0, 4'd0)};
        tbl[4]  = '{1'b0, 3'b111, pk(3'b000, 0, 1, 0, 2'd0, 4'd0)};
        tbl[5]  = '{1'b0, 3'b111, pk(3'b010, 0, 1, 0, 2'd1, 4'd0)};
        tbl[6]  = '{1'b0, 3'b111, pk(3'b010, 0, 1, 0, 2'd1, 4'd0)};
        tbl[7]  = '{1'b0, 3'b111, pk(3'b000, 0, 1, 0, 2'd1, 4'd0)};
        tbl[8]  = '{1'b0, 3'b111, pk(3'b100, 0, 1, 0, 2'd2, 4'd0)};
        tbl[9]  = '{1'b0, 3'b111, pk(3'b000, 0, 1, 0, 2'd2, 4'd0)};
        tbl[10] = '{1'b0, 3'b111, pk(3'b000, 1, 0, 0, 2'd2, 4'd0)};
        tbl[11] = '{1'b0, 3'b000, pk(3'b000, 1, 0, 0, 2'd2, 4'd0)};
        tbl[12] = '{1'b1, 3'b111, pk(3'b001, 0, 1, 0, 2'd0, 4'd0)};

        pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b0; pat[3] = 1'b1;
        pat[4] = 1'b1; pat[5] = 1'b1; pat[6] = 1'b1;

        @(posedge clk);
        @(posedge clk);
        #1;
        check_a("a_reset_state", pk(3'b000, 0, 0, 0, 2'd0, 4'd0));
        check_b("b_reset_state", pk(3'b000, 0, 0, 0, 2'd0, 4'd0));
        @(negedge clk);
        a_aclr = 1'b0;
        b_aclr = 1'b0;

        for (int i = 0; i < 13; i++) begin
            step_a(tbl[i].start, tbl[i].rdone);
            check_a($sformatf("tbl%0d", i), tbl[i].exp);
        end

        // rdone[1] stuck low: 17 edges per attempt, two retries, then FAIL.
        for (int e = 1; e <= 55; e++) begin
            step_a(1'b0, 3'b101);
            case (e)
                16: check_a("tmo_wait1",  pk(3'b000, 0, 1, 0, 2'd1, 4'd0));
                17: check_a("tmo_retry1", pk(3'b001, 0, 1, 0, 2'd0, 4'd1));
                33: check_a("tmo_wait2",  pk(3'b000, 0, 1, 0, 2'd1, 4'd1));
                34: check_a("tmo_retry2", pk(3'b001, 0, 1, 0, 2'd0, 4'd2));
                51: check_a("tmo_fail",   pk(3'b000, 0, 0, 1, 2'd1, 4'd2));
                55: check_a("fail_hold",  pk(3'b000, 0, 0, 1, 2'd1, 4'd2));
                default: ;
            endcase
        end

        step_a(1'b1, 3'b101);
        check_a("fail_restart", pk(3'b001, 0, 1, 0, 2'd0, 4'd0));

        // Start re-edge mid-WAIT of stage 1 after one retry clears retry_count.
        for (int e = 1; e <= 25; e++) begin
            step_a(1'b0, 3'b101);
            if (e == 17) check_a("mid_retry1", pk(3'b001, 0, 1, 0, 2'd0, 4'd1));
            if (e == 25) check_a("mid_wait",   pk(3'b000, 0, 1, 0, 2'd1, 4'd1));
        end
        step_a(1'b1, 3'b101);
        check_a("mid_restart", pk(3'b001, 0, 1, 0, 2'd0, 4'd0));

        // Reach stage 2 with reset[2] high, then pulse aclr with start held high.
        for (int e = 1; e <= 8; e++) step_a(1'b0, 3'b111);
        check_a("pre_aclr", pk(3'b100, 0, 1, 0, 2'd2, 4'd0));
        #2;
        a_aclr  = 1'b1;
        a_start = 1'b1;
        #1;
        check_a("aclr_async", pk(3'b000, 0, 0, 0, 2'd0, 4'd0));
        @(negedge clk);
        a_aclr = 1'b0;
        @(posedge clk);
        #1;
        check_a("aclr_restart", pk(3'b001, 0, 1, 0, 2'd0, 4'd0));

        // dut_b: stability delay of 3 on stage 0.
        step_b(1'b1, 3'b000);
        check_b("b_start", pk(3'b001, 0, 1, 0, 2'd0, 4'd0));
        step_b(1'b0, 3'b000);
        check_b("b_wait0", pk(3'b000, 0, 1, 0, 2'd0, 4'd0));
        for (int i = 0; i < 7; i++) begin
            step_b(1'b0, {2'b00, pat[i]});
            if (i < 6) check_b($sformatf("b_stab%0d", i), pk(3'b000, 0, 1, 0, 2'd0, 4'd0));
            else       check_b("b_stab_done", pk(3'b010, 0, 1, 0, 2'd1, 4'd0));
        end

        // Stage 1 holds reset until rdone[1]; no timeout in ASSERT.
        for (int i = 0; i < 20; i++) begin
            step_b(1'b0, 3'b001);
            check_b($sformatf("b_htr_hold%0d", i), pk(3'b010, 0, 1, 0, 2'd1, 4'd0));
        end
        step_b(1'b0, 3'b011);
        check_b("b_htr_fall", pk(3'b000, 0, 1, 0, 2'd1, 4'd0));
        for (int i = 0; i < 3; i++) step_b(1'b0, 3'b111);
        check_b("b_s1_stab", pk(3'b000, 0, 1, 0, 2'd1, 4'd0));
        step_b(1'b0, 3'b111);
        check_b("b_s2_rise", pk(3'b100, 0, 1, 0, 2'd2, 4'd0));
        step_b(1'b0, 3'b111);
        check_b("b_s2_fall", pk(3'b000, 0, 1, 0, 2'd2, 4'd0));
        for (int i = 0; i < 3; i++) step_b(1'b0, 3'b111);
        check_b("b_pre_done", pk(3'b000, 0, 1, 0, 2'd2, 4'd0));
        step_b(1'b0, 3'b111);
        check_b("b_done", pk(3'b000, 1, 0, 0, 2'd2, 4'd0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/altera_tse_reset_seq_chain.md
# altera_tse_reset_seq_chain

Parametrised multi-stage reset sequencer for the TSE transceiver/PCS reset tree. It replaces hand-daisy-chained single-stage reset controllers with one block that drives NUM_STAGES reset outputs in strict order. Each stage has its own hold mode and length, and a stage advances only after its done input has been stable. A per-stage timeout triggers a bounded whole-chain retry, and the block reports a sticky error when the retries are exhausted.

## Interface
Parameters:
- NUM_STAGES, 3: number of sequential reset stages (1..8).
- HOLD_CYCLES, {16'd1,16'd1,16'd1}: packed 16 bits per stage, stage 0 in bits [15:0]; reset pulse length; 0 is treated as 1.
- HOLD_TIL_RDONE, 3'b000: per-stage bit; 1 means reset stays high until rdone[i]=1, ignoring HOLD_CYCLES.
- SDONE_DELAY_CYCLES, 0: rdone[i] must be high for SDONE_DELAY_CYCLES+1 consecutive cycles before the stage completes (0..65535).
- TIMEOUT_CYCLES, 0: maximum cycles in WAIT per stage; 0 disables the timeout.
- MAX_RETRIES, 2: whole-chain restarts allowed after a timeout (0..15).

Ports:
- clock, in, 1: single clock; all logic is on the rising edge.
- aclr, in, 1: asynchronous, active-high reset; the one-clock, async active-high reset is already decided.
- start, in, 1: a 0-to-1 edge starts or restarts the sequence.
- rdone, in, NUM_STAGES: per-stage done; level-sensitive and already synchronous to clock.
- reset, out, NUM_STAGES: per-stage reset, registered.
- sdone, out, 1: whole sequence complete; sticky until the next start edge.
- busy, out, 1: high in ASSERT or WAIT.
- error, out, 1: sticky; retries exhausted.
- stage, out, max(1,$clog2(NUM_STAGES)): current stage index.
- retry_count, out, 4: retries consumed in the current sequence.

## Operation
- spulse = start & ~zstart. zstart is a register cleared by aclr, so a start held high through aclr release triggers a sequence.
- States are IDLE, ASSERT, WAIT, DONE and FAIL. There is one hold/stability counter and one timeout counter, each 16 bits, saturating.
- spulse has priority over everything in any state:
  - stage<=0, retry_count<=0, sdone<=0, error<=0, state<=ASSERT.
  - reset<=one-hot bit 0; hold counter<=max(HOLD_CYCLES[0],1)-1.
- ASSERT, timed stage (HOLD_TIL_RDONE[stage]=0):
  - Decrement the hold counter each cycle.
  - At 0: reset[stage]<=0, state<=WAIT, both counters<=0.
- ASSERT, hold-til-rdone stage (HOLD_TIL_RDONE[stage]=1):
  - When rdone[stage]=1: reset[stage]<=0, state<=WAIT, both counters<=0.
  - This stage has no timeout while in ASSERT.
- WAIT, stability counting:
  - rdone[stage]=1 and stab==SDONE_DELAY_CYCLES: the stage completes.
  - rdone[stage]=1 otherwise: stab increments.
  - rdone[stage]=0: stab<=0.
- WAIT, stage completion:
  - If stage==NUM_STAGES-1: state<=DONE, sdone<=1.
  - Otherwise: stage<=stage+1, state<=ASSERT, reset bit stage+1<=1, and the hold counter is loaded for the new stage.
- WAIT, timeout:
  - The timeout counter increments every WAIT cycle.
  - If TIMEOUT_CYCLES>0, the counter equals TIMEOUT_CYCLES-1 and the stage does not complete that cycle, a timeout fires.
  - retry_count<MAX_RETRIES: retry_count+1, then restart from stage 0 exactly as spulse does, but without clearing retry_count.
  - Otherwise: state<=FAIL, error<=1, reset<=0.
  - If completion and timeout occur in the same cycle, completion wins.
- DONE and FAIL hold until spulse. In DONE, rdone falling has no effect.
- At most one reset bit is high at any time. Earlier stages are never re-asserted except by a restart.
- aclr (asynchronous): all registers clear, state<=IDLE, every output goes to 0 immediately, including mid-sequence.

## Timing
- Reset values: reset=0, sdone=0, busy=0, error=0, stage=0, retry_count=0.
- Start latency: start rises at edge k; reset[0] is high from edge k+1.
- Timed stage: reset[i] is high for exactly max(HOLD_CYCLES[i],1) cycles.
- Stage completion: rdone[i] is first high in WAIT at cycle j and stays high. The stage completes at edge j+SDONE_DELAY_CYCLES+1, and reset[i+1] rises on that same edge.
- Hold-til-rdone stage: reset[i] falls on the edge after rdone[i] is first seen high. WAIT then begins its stability count.
- sdone rises on the completion edge of the last stage. busy falls on the same edge.
- Timeout restart: reset[0] rises on the edge at which the timeout fires.

## Test plan
- N=3, HOLD={4,2,1}, delay 0, rdone tied 1, start pulse:
  - reset[0] high 4 cycles, then reset[1] 1 cycle later for 2 cycles, then reset[2] 1 cycle later for 1 cycle.
  - sdone rises 1 cycle after reset[2] falls.
- SDONE_DELAY=3, rdone[0] toggles 1,1,0,1,1,1,1: completion occurs only after 4 consecutive highs. stage=1 on the 4th high's edge.
- HOLD_TIL_RDONE[1]=1, rdone[1] low for 20 cycles, then high: reset[1] is high for 21 cycles and falls 1 edge after rdone[1] rises.
- TIMEOUT=10, MAX_RETRIES=2, rdone[1] stuck 0:
  - Two restarts occur; retry_count reads 1, then 2.
  - Then FAIL: error=1, reset=0, busy=0.
  - A later start edge clears error and restarts the sequence.
- aclr pulsed while stage=2 and reset[2]=1: all outputs are 0 asynchronously. With start held high at aclr release, the sequence restarts with reset[0] one edge later.
- start re-edge in DONE: sdone falls and reset[0] rises on the same edge. A start re-edge mid-WAIT of stage 1 restarts from stage 0 with retry_count=0.
